// File: rtl/alu_issue.sv
// ALU issue stage: registers the decoded instruction from ID, resolves operands
// and ALU opcode for EX, and stalls on load-use. Optional operand forwarding: ALU_ISSUE_FWD_EN.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  input  logic        ex_stall,
  input  logic        flush,
  input  logic        exmem_wen,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_wen,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        out_valid,
  output logic [4:0]  out_rd,
  output logic        out_is_load,
  output logic        illegal
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                         A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                         A_OR = 4'd8, A_AND = 4'd9;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
  } stage_t;

  stage_t stg;
  logic   vld;
  logic   hazard, xfer;
  logic   use1, use2;
  logic   hit_ex, hit_ex_mem, hit_ex_wb;

  function automatic logic src_hit(input logic en, input logic [4:0] rd,
                                   input logic u1, input logic [4:0] a1,
                                   input logic u2, input logic [4:0] a2);
    return en && (rd != 5'd0) && ((u1 && rd == a1) || (u2 && rd == a2));
  endfunction

  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? A_SUB : A_ADD;
      3'b001:  return A_SLL;
      3'b010:  return A_SLT;
      3'b011:  return A_SLTU;
      3'b100:  return A_XOR;
      3'b101:  return f7 ? A_SRA : A_SRL;
      3'b110:  return A_OR;
      default: return A_AND;
    endcase
  endfunction

  // Which sources the incoming instruction actually reads
  always_comb begin
    use1 = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LD) ||
           (opcode == OP_ST) || (opcode == OP_BR) || (opcode == OP_JLR);
    use2 = (opcode == OP_R) || (opcode == OP_ST) || (opcode == OP_BR);
  end

  assign hit_ex     = src_hit(vld, stg.rd, use1, rs1_addr, use2, rs2_addr);
  assign hit_ex_mem = src_hit(exmem_wen, exmem_rd, use1, rs1_addr, use2, rs2_addr);
  assign hit_ex_wb  = src_hit(memwb_wen, memwb_rd, use1, rs1_addr, use2, rs2_addr);

`ifdef ALU_ISSUE_FWD_EN
  assign hazard = hit_ex && (stg.opcode == OP_LD);

  function automatic logic [31:0] src_val(input logic [4:0] a, input logic [31:0] d,
                                          input logic ew, input logic [4:0] er, input logic [31:0] ed,
                                          input logic mw, input logic [4:0] mr, input logic [31:0] md);
    if (a == 5'd0)          return 32'd0;
    else if (ew && er == a) return ed;
    else if (mw && mr == a) return md;
    else                    return d;
  endfunction

  logic [31:0] s1, s2;
  assign s1 = src_val(stg.rs1_addr, stg.rs1_data, exmem_wen, exmem_rd, exmem_result,
                      memwb_wen, memwb_rd, memwb_result);
  assign s2 = src_val(stg.rs2_addr, stg.rs2_data, exmem_wen, exmem_rd, exmem_result,
                      memwb_wen, memwb_rd, memwb_result);
`else
  // Without forwarding any in-flight producer of a source blocks issue
  assign hazard = hit_ex || hit_ex_mem || hit_ex_wb;

  logic [31:0] s1, s2;
  logic        unused_fwd;
  assign s1 = (stg.rs1_addr == 5'd0) ? 32'd0 : stg.rs1_data;
  assign s2 = (stg.rs2_addr == 5'd0) ? 32'd0 : stg.rs2_data;
  assign unused_fwd = ^{exmem_result, memwb_result};
`endif

  assign in_ready = !ex_stall && !hazard;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg <= '0;
      vld <= 1'b0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (!ex_stall) begin
      vld <= xfer;
      if (xfer) stg <= '{opcode, funct3, funct7b5, rs1_addr, rs2_addr, rd_addr,
                         rs1_data, rs2_data, imm, pc};
    end
  end

  logic ill;
  always_comb begin
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = A_ADD;
    ill    = 1'b0;
    case (stg.opcode)
      OP_R:   begin alu_a = s1; alu_b = s2; alu_op = f3_op(stg.funct3, stg.funct7b5, 1'b1); end
      OP_I:   begin alu_a = s1; alu_b = stg.imm; alu_op = f3_op(stg.funct3, stg.funct7b5, 1'b0); end
      OP_LD,
      OP_ST:  begin alu_a = s1; alu_b = stg.imm; end
      OP_LUI: alu_b = stg.imm;
      OP_AUI: begin alu_a = stg.pc; alu_b = stg.imm; end
      OP_JAL,
      OP_JLR: begin alu_a = stg.pc; alu_b = 32'd4; end
      OP_BR: begin
        case (stg.funct3)
          3'b000, 3'b001: begin alu_a = s1; alu_b = s2; alu_op = A_SUB;  end
          3'b100, 3'b101: begin alu_a = s1; alu_b = s2; alu_op = A_SLT;  end
          3'b110, 3'b111: begin alu_a = s1; alu_b = s2; alu_op = A_SLTU; end
          default:        ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  end

  // Cleared stage decodes as opcode 0; only a live instruction may flag illegal
  assign illegal     = vld && ill;
  assign out_valid   = vld;
  assign out_rd      = stg.rd;
  assign out_is_load = (stg.opcode == OP_LD);
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode, operand select, load-use, stall/flush, reset.
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic        ex_stall, flush;
  logic        exmem_wen, memwb_wen;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        out_valid, out_is_load, illegal;
  logic [4:0]  out_rd;
  int          errors = 0;
  int          checks = 0;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .ex_stall(ex_stall), .flush(flush),
    .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_wen(memwb_wen), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_valid(out_valid),
    .out_rd(out_rd), .out_is_load(out_is_load), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic [31:0] d1, input logic [31:0] d2,
                     input logic [31:0] im, input logic [31:0] p);
    opcode = op; funct3 = f3; funct7b5 = f7;
    rs1_addr = r1; rs2_addr = r2; rd_addr = rd;
    rs1_data = d1; rs2_data = d2; imm = im; pc = p;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    exmem_wen = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_wen = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
    drv(7'h33, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    in_valid = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op", {28'd0, alu_op}, 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_b", alu_b, 32'd0);
    chk("rst_ill", {31'd0, illegal}, 32'd0);
    chk("rst_load", {31'd0, out_is_load}, 32'd0);
    chk("rst_rd", {27'd0, out_rd}, 32'd0);
    rst_n = 1'b1; #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // sub x3,x1,x2
    drv(7'h33, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 32'd0);
    tick();
    chk("sub_op", {28'd0, alu_op}, 32'd1);
    chk("sub_a", alu_a, 32'd10);
    chk("sub_b", alu_b, 32'd3);
    chk("sub_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_rd", {27'd0, out_rd}, 32'd3);
    in_valid = 1'b0;
    tick();
    chk("bubble_valid", {31'd0, out_valid}, 32'd0);

    // lw x5,8(x1) then load-use add x6,x5,x5
    drv(7'h03, 3'd2, 1'b0, 5'd1, 5'd0, 5'd5, 32'd100, 32'd0, 32'd8, 32'd0);
    tick();
    chk("lw_load", {31'd0, out_is_load}, 32'd1);
    chk("lw_a", alu_a, 32'd100);
    chk("lw_b", alu_b, 32'd8);
    chk("lw_op", {28'd0, alu_op}, 32'd0);
    drv(7'h33, 3'd0, 1'b0, 5'd5, 5'd5, 5'd6, 32'd7, 32'd9, 32'd0, 32'd0);
    #1;
    chk("lu_ready0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lu_bubble", {31'd0, out_valid}, 32'd0);
    chk("lu_ready1", {31'd0, in_ready}, 32'd1);
    tick();
    chk("lu_issue", {31'd0, out_valid}, 32'd1);
    chk("lu_a", alu_a, 32'd7);
    chk("lu_b", alu_b, 32'd9);
    chk("lu_rd", {27'd0, out_rd}, 32'd6);

    // stall holds, then stall+flush kills
    in_valid = 1'b0; ex_stall = 1'b1; #1;
    chk("stall_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_a", alu_a, 32'd7);
    drv(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 5'd9, 32'd1, 32'd1, 32'd0, 32'd0);
    flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; ex_stall = 1'b0;

    // srai x7,x1,5 (imm 0x405)
    drv(7'h13, 3'd5, 1'b1, 5'd1, 5'd0, 5'd7, 32'h8000_0000, 32'd0, 32'h405, 32'd0);
    tick();
    chk("srai_op", {28'd0, alu_op}, 32'd7);
    chk("srai_a", alu_a, 32'h8000_0000);
    chk("srai_b", alu_b, 32'h405);
    chk("srai_ill", {31'd0, illegal}, 32'd0);

    // unlisted opcode
    drv(7'h7F, 3'd0, 1'b0, 5'd1, 5'd2, 5'd8, 32'd5, 32'd6, 32'd7, 32'd8);
    tick();
    chk("bad_ill", {31'd0, illegal}, 32'd1);
    chk("bad_valid", {31'd0, out_valid}, 32'd1);
    chk("bad_a", alu_a, 32'd0);
    chk("bad_b", alu_b, 32'd0);
    chk("bad_op", {28'd0, alu_op}, 32'd0);

    // lui / auipc / jal
    drv(7'h37, 3'd0, 1'b0, 5'd0, 5'd0, 5'd10, 32'd1, 32'd1, 32'h1234_5000, 32'h40);
    tick();
    chk("lui_a", alu_a, 32'd0);
    chk("lui_b", alu_b, 32'h1234_5000);
    drv(7'h17, 3'd0, 1'b0, 5'd0, 5'd0, 5'd11, 32'd1, 32'd1, 32'h20, 32'h1000);
    tick();
    chk("auipc_a", alu_a, 32'h1000);
    chk("auipc_b", alu_b, 32'h20);
    drv(7'h6F, 3'd0, 1'b0, 5'd0, 5'd0, 5'd12, 32'd1, 32'd1, 32'h80, 32'h2000);
    tick();
    chk("jal_a", alu_a, 32'h2000);
    chk("jal_b", alu_b, 32'd4);
    chk("jal_op", {28'd0, alu_op}, 32'd0);

    // bltu, then reserved branch funct3
    drv(7'h63, 3'd6, 1'b0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd6, 32'd16, 32'd0);
    tick();
    chk("bltu_op", {28'd0, alu_op}, 32'd4);
    chk("bltu_b", alu_b, 32'd6);
    drv(7'h63, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd6, 32'd16, 32'd0);
    tick();
    chk("br010_ill", {31'd0, illegal}, 32'd1);

    // x0 source reads as zero; or / sll mapping
    drv(7'h33, 3'd6, 1'b0, 5'd0, 5'd2, 5'd8, 32'hDEAD, 32'h3, 32'd0, 32'd0);
    tick();
    chk("x0_a", alu_a, 32'd0);
    chk("or_op", {28'd0, alu_op}, 32'd8);
    drv(7'h33, 3'd1, 1'b0, 5'd1, 5'd2, 5'd13, 32'd1, 32'd2, 32'd0, 32'd0);
    tick();
    chk("sll_op", {28'd0, alu_op}, 32'd2);

    // add x4,x1,x0 with x1 in flight at EX/MEM and MEM/WB
    exmem_wen = 1'b1; exmem_rd = 5'd1; exmem_result = 32'h55;
    memwb_wen = 1'b1; memwb_rd = 5'd1; memwb_result = 32'h66;
    drv(7'h33, 3'd0, 1'b0, 5'd1, 5'd0, 5'd4, 32'h11, 32'hBEEF, 32'd0, 32'd0);
`ifdef ALU_ISSUE_FWD_EN
    tick();
    chk("fwd_a", alu_a, 32'h55);
    chk("fwd_b", alu_b, 32'd0);
    in_valid = 1'b0; exmem_wen = 1'b0; #1;
    chk("fwd_wb_a", alu_a, 32'h66);
    memwb_wen = 1'b0;
`else
    #1;
    chk("nofwd_ready0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("nofwd_bubble", {31'd0, out_valid}, 32'd0);
    exmem_wen = 1'b0; #1;
    chk("nofwd_wb_ready0", {31'd0, in_ready}, 32'd0);
    memwb_wen = 1'b0; #1;
    chk("nofwd_ready1", {31'd0, in_ready}, 32'd1);
    tick();
    chk("nofwd_a", alu_a, 32'h11);
    chk("nofwd_b", alu_b, 32'd0);
`endif

    // reset while a load-use hazard is pending
    drv(7'h03, 3'd2, 1'b0, 5'd1, 5'd0, 5'd5, 32'd100, 32'd0, 32'd8, 32'd0);
    tick();
    drv(7'h33, 3'd0, 1'b0, 5'd5, 5'd5, 5'd6, 32'd7, 32'd9, 32'd0, 32'd0);
    #1;
    chk("rh_ready0", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("rh_valid", {31'd0, out_valid}, 32'd0);
    chk("rh_load", {31'd0, out_is_load}, 32'd0);
    rst_n = 1'b1; #1;
    chk("rh_ready1", {31'd0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have inputs in_valid (1) and in_ready output (1): ID-side handshake, transfer when both high at a clk edge.
REQ-004 SHALL have inputs opcode (7), funct3 (3), funct7b5 (1), rs1_addr/rs2_addr/rd_addr (5 each), rs1_data/rs2_data/imm/pc (32 each): decoded instruction from ID.
REQ-005 SHALL have inputs ex_stall (1) (hold stage) and flush (1) (kill stage contents).
REQ-006 SHALL have inputs exmem_wen (1), exmem_rd (5), exmem_result (32), memwb_wen (1), memwb_rd (5), memwb_result (32): forwarding sources.
REQ-007 SHALL have outputs alu_a (32), alu_b (32), alu_op (4), out_valid (1), out_rd (5), out_is_load (1), illegal (1): drive the ALU and EX/MEM register.

Function
REQ-008 SHALL register all ID inputs into the stage register on transfer; outputs SHALL derive from the stage register only (one-cycle latency ID->EX).
REQ-009 SHALL drive in_ready = !ex_stall && !hazard, combinationally.
REQ-010 SHALL hold the stage register and all outputs unchanged while ex_stall=1 and flush=0.
REQ-011 SHALL clear out_valid at the next edge when flush=1, regardless of ex_stall, in_valid or hazard; flush wins over every other event.
REQ-012 SHALL load out_valid=0 (bubble) when not stalled and no transfer occurs.
REQ-013 SHALL assert hazard when out_valid=1, out_is_load=1, out_rd!=0 and out_rd equals an incoming source register the incoming instruction uses; the result is exactly one bubble.
REQ-014 SHALL encode alu_op as ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
REQ-015 SHALL map funct3 for OP/OP-IMM as: 000 ADD (SUB only for OP with funct7b5=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL or SRA by funct7b5, 110 OR, 111 AND.
REQ-016 SHALL select operands: OP a=rs1,b=rs2; OP-IMM/LOAD/STORE/JALR-target a=rs1,b=imm with ADD for LOAD/STORE; LUI a=0,b=imm; AUIPC a=pc,b=imm; JAL/JALR a=pc,b=4 op ADD.
REQ-017 SHALL select operands for BRANCH as a=rs1,b=rs2 with op SUB for funct3 000/001, SLT for 100/101, SLTU for 110/111; funct3 010/011 SHALL set illegal.
REQ-018 SHALL set illegal=1 for any unlisted opcode, with alu_op=ADD and a=b=0; out_valid still reflects the stage.
REQ-019 SHALL forward onto rs1/rs2 operand paths combinationally: EX/MEM match (wen=1, rd!=0, rd==src) has priority over MEM/WB match; else register data.
REQ-020 SHALL never forward for source x0; operand is 0 when its address is 0.
REQ-021 SHALL set out_is_load=1 exactly for opcode LOAD.

Reset
REQ-022 SHALL on rst_n=0 clear out_valid, out_rd, out_is_load, illegal, and stage register to 0; alu_op=ADD, alu_a=alu_b=0.
REQ-023 SHALL on reset mid-stall or mid-hazard discard the held instruction; in_ready SHALL be 1 in the first cycle after reset release when ex_stall=0.

Configuration
REQ-024 SHALL implement forwarding (REQ-019) only when ALU_ISSUE_FWD_EN is defined.
REQ-025 SHALL, without ALU_ISSUE_FWD_EN, ignore all forwarding inputs except rd/wen and extend hazard to any nonzero source match against out_rd (if out_valid), exmem_rd (if exmem_wen) or memwb_rd (if memwb_wen), stalling until clear.

Verification
REQ-026 SHALL cover: OP sub x3,x1,x2 with rs1=10, rs2=3 -> next cycle alu_op=1, a=10, b=3, out_valid=1.
REQ-027 SHALL cover: FWD_EN, exmem_rd=1 result=0x55, memwb_rd=1 result=0x66, add x4,x1,x0 -> alu_a=0x55, alu_b=0.
REQ-028 SHALL cover: lw x5 in stage, incoming add x6,x5,x5 -> in_ready=0 one cycle, one bubble, then add issues.
REQ-029 SHALL cover: ex_stall=1 and flush=1 same cycle with valid add in stage -> out_valid=0 next cycle.
REQ-030 SHALL cover: srai imm=0x405 (funct7b5=1), rs1=0x80000000 -> alu_op=7, b=0x405; opcode 0x7F -> illegal=1.
